// File: rtl/i2c_sda_datapath.sv
// i2c_sda_datapath
//   Bit-level SDA engine of the I2C master. It executes byte-level
//   START / WRITE / READ / STOP commands from the master FSM. It times
//   every bit from the edges of the scl level produced by the SCL generator.
//   Transmit bytes are sent MSB first. Receive bytes are shifted in MSB
//   first. SDA is open-drain: sda_oe=1 pulls the line low.
//
//   Optional build macro: I2C_ARB_LOST_EN
//     When defined, a 1 being sent in WR_BIT that reads back as 0 on an
//     scl rise aborts the transfer and pulses arb_lost.
//     When undefined, arb_lost is tied 0.
//
//   Parameters
//     DATA_LEN   bits per data/address byte, ACK excluded (>= 2)
//     STOP_HOLD  clk cycles scl must be seen high before SDA is released
//                for STOP (>= 1)
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     scl          SCL level from the SCL generator
//     sda_in       sampled SDA line level
//     cmd_valid    command request
//     cmd          00=START 01=WRITE 10=READ 11=STOP
//     cmd_ready    command accepted when high together with cmd_valid
//     tx_byte      byte to send, latched on WRITE acceptance
//     ack_out      ACK driven after READ (0=ACK), latched on acceptance
//     sda_oe       1 = drive SDA low
//     rx_byte      last received byte
//     ack_in       ACK sampled after WRITE (0=ACK)
//     done         one-cycle pulse at command completion
//     busy         high whenever not IDLE
//     arb_lost     arbitration-loss pulse
module i2c_sda_datapath #(
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned STOP_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                sda_in,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd,
  output logic                cmd_ready,
  input  logic [DATA_LEN-1:0] tx_byte,
  input  logic                ack_out,
  output logic                sda_oe,
  output logic [DATA_LEN-1:0] rx_byte,
  output logic                ack_in,
  output logic                done,
  output logic                busy,
  output logic                arb_lost
);

  localparam int unsigned CNT_W  = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int unsigned HOLD_W = (STOP_HOLD > 1) ? $clog2(STOP_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STOP_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WR_BIT,
    S_WR_ACK,
    S_RD_BIT,
    S_RD_ACK,
    S_STOP_LOW,
    S_STOP_HIGH
  } state_e;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_e;

  state_e              state_q, state_d;
  logic                sda_oe_q, sda_oe_d;
  logic                done_q, done_d;
  logic [DATA_LEN-1:0] rx_q, rx_d;
  logic [DATA_LEN-1:0] shreg_q, shreg_d;
  logic                ack_in_q, ack_in_d;
  logic                ack_out_q, ack_out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                scl_q;
  logic                scl_fall, scl_rise;
  logic                accept;
  logic                arb_hit;
  cmd_e                cmd_dec;

  assign cmd_dec  = cmd_e'(cmd);
  assign scl_fall = scl_q & ~scl;
  assign scl_rise = ~scl_q & scl;

  assign sda_oe  = sda_oe_q;
  assign done    = done_q;
  assign rx_byte = rx_q;
  assign ack_in  = ack_in_q;
  assign busy    = (state_q != S_IDLE);

  // START must be issued with scl high; every other command with scl low.
  always_comb begin
    cmd_ready = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_dec == CMD_START) cmd_ready = scl;
      else                      cmd_ready = ~scl;
    end
  end

  assign accept = cmd_valid & cmd_ready;

`ifdef I2C_ARB_LOST_EN
  logic arb_q;

  // A released line (sending 1) read back low means another master won.
  assign arb_hit  = (state_q == S_WR_BIT) & scl_rise & ~sda_oe_q & ~sda_in;
  assign arb_lost = arb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_q <= 1'b0;
    else        arb_q <= arb_hit;
  end
`else
  assign arb_hit  = 1'b0;
  assign arb_lost = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sda_oe_d  = sda_oe_q;
    done_d    = 1'b0;
    rx_d      = rx_q;
    shreg_d   = shreg_q;
    ack_in_d  = ack_in_q;
    ack_out_d = ack_out_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_dec)
            CMD_START: begin
              sda_oe_d = 1'b1;
              state_d  = S_START;
            end
            CMD_WRITE: begin
              shreg_d  = tx_byte;
              sda_oe_d = ~tx_byte[DATA_LEN-1];
              cnt_d    = CNT_LAST;
              state_d  = S_WR_BIT;
            end
            CMD_READ: begin
              ack_out_d = ack_out;
              sda_oe_d  = 1'b0;
              cnt_d     = CNT_LAST;
              state_d   = S_RD_BIT;
            end
            default: begin
              sda_oe_d = 1'b1;
              state_d  = S_STOP_LOW;
            end
          endcase
        end
      end

      S_START: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_WR_BIT: begin
        if (arb_hit) begin
          sda_oe_d = 1'b0;
          state_d  = S_IDLE;
        end else if (scl_fall) begin
          if (cnt_q != '0) begin
            // The shift register's MSB is always the bit on the wire.
            cnt_d    = cnt_q - CNT_W'(1);
            shreg_d  = {shreg_q[DATA_LEN-2:0], 1'b0};
            sda_oe_d = ~shreg_q[DATA_LEN-2];
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_WR_ACK;
          end
        end
      end

      S_WR_ACK: begin
        if (scl_rise) begin
          ack_in_d = sda_in;
        end else if (scl_fall) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RD_BIT: begin
        if (scl_rise) begin
          rx_d = {rx_q[DATA_LEN-2:0], sda_in};
        end else if (scl_fall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            sda_oe_d = ~ack_out_q;
            state_d  = S_RD_ACK;
          end
        end
      end

      S_RD_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_STOP_LOW: begin
        if (scl_rise) begin
          hold_d  = '0;
          state_d = S_STOP_HIGH;
        end
      end

      S_STOP_HIGH: begin
        // scl dropping before the hold time expires restarts the wait.
        if (!scl) begin
          state_d = S_STOP_LOW;
        end else if (hold_q == HOLD_LAST) begin
          sda_oe_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sda_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      rx_q      <= '0;
      shreg_q   <= '0;
      ack_in_q  <= 1'b1;
      ack_out_q <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      scl_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      sda_oe_q  <= sda_oe_d;
      done_q    <= done_d;
      rx_q      <= rx_d;
      shreg_q   <= shreg_d;
      ack_in_q  <= ack_in_d;
      ack_out_q <= ack_out_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      scl_q     <= scl;
    end
  end

endmodule

// File: tb/tb_i2c_sda_datapath.sv
// Directed bench for i2c_sda_datapath: a per-cycle vector table for the
// START / cmd_ready gating behaviour, plus hand-written multi-cycle
// sequences for WRITE, READ, STOP, reset abort and arbitration loss.
module tb_i2c_sda_datapath;

  localparam int unsigned DATA_LEN  = 8;
  localparam int unsigned STOP_HOLD = 2;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_in;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [7:0] tx_byte;
  logic       ack_out;
  logic       sda_oe;
  logic [7:0] rx_byte;
  logic       ack_in;
  logic       done;
  logic       busy;
  logic       arb_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_sda_datapath #(
    .DATA_LEN (DATA_LEN),
    .STOP_HOLD(STOP_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_in   (sda_in),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready),
    .tx_byte  (tx_byte),
    .ack_out  (ack_out),
    .sda_oe   (sda_oe),
    .rx_byte  (rx_byte),
    .ack_in   (ack_in),
    .done     (done),
    .busy     (busy),
    .arb_lost (arb_lost)
  );

  typedef struct {
    logic       valid;
    logic [1:0] cmd;
    logic       scl;
    logic       exp_ready;
    logic       exp_oe;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clk cycle: inputs change just after posedge, outputs are sampled at negedge.
  task automatic cyc(input logic scl_v, input logic sda_v, input logic valid_v, input logic [1:0] cmd_v);
    @(posedge clk);
    #1;
    scl       = scl_v;
    sda_in    = sda_v;
    cmd_valid = valid_v;
    cmd       = cmd_v;
    @(negedge clk);
  endtask

  // Full WRITE or READ byte: 9 slots of 1 low + 2 high scl cycles, then the final fall.
  // ackb is the slave ACK for a WRITE, or the master's ack_out for a READ.
  task automatic xfer(input logic rd, input logic [7:0] data, input logic ackb);
    logic exp_oe;
    logic line;
    tx_byte = data;
    ack_out = ackb;
    cyc(1'b0, 1'b1, 1'b1, rd ? C_READ : C_WRITE);
    check(rd ? "rd_accept_ready" : "wr_accept_ready", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        exp_oe = rd ? 1'b0 : ~data[7-i];
        line   = data[7-i];
      end else begin
        exp_oe = rd ? ~ackb : 1'b0;
        line   = ackb;
      end
      cyc(1'b0, 1'b1, 1'b0, C_START);
      cyc(1'b1, line, 1'b0, C_START);
      cyc(1'b1, line, 1'b0, C_START);
      check($sformatf("%s_slot%0d_oe", rd ? "rd" : "wr", i), 32'(sda_oe), 32'(exp_oe));
      check($sformatf("%s_slot%0d_done", rd ? "rd" : "wr", i), 32'(done), 32'(0));
      check($sformatf("%s_slot%0d_arb", rd ? "rd" : "wr", i), 32'(arb_lost), 32'(0));
    end
    cyc(1'b0, 1'b1, 1'b0, C_START);
    check("xfer_last_fall_done", 32'(done), 32'(0));
    check("xfer_last_fall_busy", 32'(busy), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, C_WRITE);
    check("xfer_done", 32'(done), 32'(1));
    check("xfer_done_busy", 32'(busy), 32'(0));
    check("xfer_done_oe", 32'(sda_oe), 32'(0));
    check("xfer_b2b_ready", 32'(cmd_ready), 32'(1));
    if (rd) check("rd_rx_byte", 32'(rx_byte), 32'(data));
    else    check("wr_ack_in", 32'(ack_in), 32'(ackb));
    cyc(1'b0, 1'b1, 1'b0, C_START);
    check("xfer_done_pulse_end", 32'(done), 32'(0));
  endtask

  // STOP: 3 scl-low cycles, optionally a short high glitch, then a release after STOP_HOLD.
  task automatic stop_seq(input logic glitch);
    cyc(1'b0, 1'b1, 1'b1, C_STOP);
    check("stop_accept_ready", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, C_START);
      check($sformatf("stop_low%0d_oe", i), 32'(sda_oe), 32'(1));
      check($sformatf("stop_low%0d_busy", i), 32'(busy), 32'(1));
    end
    if (glitch) begin
      cyc(1'b1, 1'b1, 1'b0, C_START);
      cyc(1'b1, 1'b1, 1'b0, C_START);
      cyc(1'b0, 1'b1, 1'b0, C_START);
      check("stop_glitch_oe", 32'(sda_oe), 32'(1));
      check("stop_glitch_done", 32'(done), 32'(0));
      cyc(1'b0, 1'b1, 1'b0, C_START);
      check("stop_glitch_low_oe", 32'(sda_oe), 32'(1));
      check("stop_glitch_low_done", 32'(done), 32'(0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, C_START);
      check($sformatf("stop_high%0d_oe", i), 32'(sda_oe), 32'(1));
      check($sformatf("stop_high%0d_done", i), 32'(done), 32'(0));
    end
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("stop_release_oe", 32'(sda_oe), 32'(0));
    check("stop_release_done", 32'(done), 32'(1));
    check("stop_release_busy", 32'(busy), 32'(0));
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("stop_done_pulse_end", 32'(done), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    scl       = 1'b1;
    sda_in    = 1'b1;
    cmd_valid = 1'b0;
    cmd       = C_START;
    tx_byte   = 8'h00;
    ack_out   = 1'b0;

    //           valid cmd      scl   ready oe    done  busy
    vecs[0] = '{1'b1, C_START, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, C_START, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, C_START, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, C_START, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, C_WRITE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, C_STOP,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, C_WRITE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_rx_byte", 32'(rx_byte), 32'(0));
    check("rst_ack_in", 32'(ack_in), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_arb_lost", 32'(arb_lost), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].scl, 1'b1, vecs[i].valid, vecs[i].cmd);
      check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_oe", i), 32'(sda_oe), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_arb", i), 32'(arb_lost), 32'(0));
    end

    xfer(1'b0, 8'hA5, 1'b0);
    xfer(1'b0, 8'h5A, 1'b1);
    xfer(1'b1, 8'h3C, 1'b1);
    xfer(1'b1, 8'hC3, 1'b0);
    stop_seq(1'b0);
    stop_seq(1'b1);

    // START, then reset during bit 4 of a WRITE.
    cyc(1'b1, 1'b1, 1'b1, C_START);
    check("rst_seq_start_ready", 32'(cmd_ready), 32'(1));
    cyc(1'b1, 1'b1, 1'b0, C_START);
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("rst_seq_start_done", 32'(done), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, C_START);
    tx_byte = 8'hA5;
    cyc(1'b0, 1'b1, 1'b1, C_WRITE);
    check("rst_seq_wr_ready", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, C_START);
      cyc(1'b1, 1'b1, 1'b0, C_START);
      cyc(1'b1, 1'b1, 1'b0, C_START);
    end
    cyc(1'b0, 1'b1, 1'b0, C_START);
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("rst_seq_bit4_oe", 32'(sda_oe), 32'(1));
    check("rst_seq_bit4_busy", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", 32'(sda_oe), 32'(0));
    check("rst_async_busy", 32'(busy), 32'(0));
    check("rst_async_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("rst_after_done", 32'(done), 32'(0));
    check("rst_after_busy", 32'(busy), 32'(0));
    cyc(1'b1, 1'b1, 1'b1, C_START);
    check("rst_after_start_ready", 32'(cmd_ready), 32'(1));
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("rst_after_start_oe", 32'(sda_oe), 32'(1));
    check("rst_after_start_busy", 32'(busy), 32'(1));
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("rst_after_start_done", 32'(done), 32'(1));

`ifdef I2C_ARB_LOST_EN
    cyc(1'b0, 1'b1, 1'b0, C_START);
    tx_byte = 8'h80;
    cyc(1'b0, 1'b1, 1'b1, C_WRITE);
    check("arb_wr_ready", 32'(cmd_ready), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, C_START);
    check("arb_bit7_oe", 32'(sda_oe), 32'(0));
    cyc(1'b1, 1'b0, 1'b0, C_START);
    check("arb_rise_cycle", 32'(arb_lost), 32'(0));
    cyc(1'b1, 1'b0, 1'b0, C_START);
    check("arb_pulse", 32'(arb_lost), 32'(1));
    check("arb_oe", 32'(sda_oe), 32'(0));
    check("arb_no_done", 32'(done), 32'(0));
    check("arb_busy", 32'(busy), 32'(0));
    cyc(1'b1, 1'b1, 1'b0, C_START);
    check("arb_pulse_end", 32'(arb_lost), 32'(0));
    check("arb_no_done_later", 32'(done), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_sda_datapath.md
Name: i2c_sda_datapath

Overview:
- Bit-level SDA engine of the I2C master. Sits beside the SCL generator and consumes its `scl` output.
- The master FSM issues byte-level commands: START, WRITE, READ, STOP.
- The block serialises transmit bytes MSB first, deserialises receive bytes and samples or drives the ACK bit.
- Output is open-drain style: `sda_oe`=1 pulls the line low; `sda_oe`=0 releases it.

Parameters:
- DATA_LEN, 8: bits per data/address byte, ACK bit excluded.
- STOP_HOLD, 2: clk cycles SCL must be seen high before SDA is released for STOP.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scl  input  1  SCL level from the SCL generator
- sda_in  input  1  sampled SDA line level
- cmd_valid  input  1  command request
- cmd  input  2  00=START, 01=WRITE, 10=READ, 11=STOP
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid
- tx_byte  input  DATA_LEN  byte to send; latched on WRITE acceptance
- ack_out  input  1  ACK value driven after READ (0=ACK, 1=NACK); latched on acceptance
- sda_oe  output  1  1 = drive SDA low
- rx_byte  output  DATA_LEN  last received byte
- ack_in  output  1  ACK bit sampled after WRITE (0=ACK)
- done  output  1  one-cycle pulse at command completion
- busy  output  1  high whenever the state is not IDLE
- arb_lost  output  1  arbitration-loss pulse (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - state=IDLE, sda_oe=0, rx_byte=0, ack_in=1, done=0, arb_lost=0.
  - Bit counter=0, scl_q=1.
- Reset mid-operation aborts immediately and releases SDA. No done pulse is generated.
- Edge detection: scl_q is scl registered each clk.
  - scl_fall = scl_q & ~scl.
  - scl_rise = ~scl_q & scl.
  - sda_in is sampled in the scl_rise cycle.
- States: IDLE, START, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP_LOW, STOP_HIGH.
- cmd_ready is high only in IDLE, and only when the scl level matches the command:
  - START requires scl=1.
  - WRITE, READ and STOP require scl=0.
  - Otherwise the command waits; cmd_valid must stay asserted.
- START: on accept → START. Next cycle sda_oe=1, done=1, → IDLE. SDA stays low.
- WRITE: on accept, latch tx_byte and set sda_oe=~tx_byte[DATA_LEN-1] on the next cycle (latency 1); bit counter=DATA_LEN-1; → WR_BIT.
  - On each scl_fall: if counter>0, decrement it and drive the next bit.
  - On the scl_fall after bit 0: sda_oe=0, → WR_ACK.
  - WR_ACK: on scl_rise, ack_in<=sda_in. On the following scl_fall, done=1, → IDLE.
- READ: on accept, sda_oe=0, counter=DATA_LEN-1, → RD_BIT.
  - On each scl_rise, shift sda_in into rx_byte from the LSB side (MSB received first).
  - On the scl_fall after the last bit: sda_oe=~ack_out, → RD_ACK.
  - RD_ACK: on the next scl_fall, sda_oe=0, done=1, → IDLE.
  - rx_byte updates only on rising-edge samples, so it is stable when done fires.
- STOP: on accept, sda_oe=1 next cycle, → STOP_LOW.
  - STOP_LOW: on scl_rise, → STOP_HIGH with the hold counter cleared.
  - STOP_HIGH: count clk cycles while scl=1. At STOP_HOLD, sda_oe=0, done=1, → IDLE.
  - If scl falls during STOP_HIGH, return to STOP_LOW and keep sda_oe=1.
- Ending on an scl_fall leaves scl low, so a back-to-back WRITE/READ/STOP is accepted in the cycle after done.
- Commands presented while busy are ignored (cmd_ready=0).
- done and arb_lost never assert in the same cycle.

Optional Feature:
- Macro: I2C_ARB_LOST_EN.
- When defined, arbitration-loss detection is active:
  - Applies in WR_BIT only.
  - Trigger: on scl_rise, sda_oe=0 (a 1 is being sent) and sda_in=0.
  - Response next cycle: sda_oe=0, arb_lost=1 for one cycle, no done, → IDLE.
- When undefined, arb_lost is tied 0 and WR_BIT ignores sda_in.

Test Plan:
- START with scl=1 → sda_oe rises 1 cycle after accept; done pulses once; busy low afterwards; cmd_ready stays 0 while scl=0.
- WRITE tx_byte=8'hA5, slave sda_in=0 at the 9th scl_rise → sda_oe sequence per slot is 0,1,0,1,1,0,1,0, then 0 during the ACK slot; ack_in=0; done on the 9th scl_fall.
- READ with slave bits 8'h3C and ack_out=1 → rx_byte=8'h3C; sda_oe=0 during the ACK slot; done on the 9th scl_fall.
- STOP with STOP_HOLD=2 and scl low for 3 cycles then high → sda_oe=1 until 2 cycles after scl rises, then 0 together with the done pulse.
- rst_n asserted midway through a WRITE (bit 4) → sda_oe=0 and busy=0 immediately; no done; next START accepted normally.
- With I2C_ARB_LOST_EN: WRITE 8'h80 with sda_in forced 0 at the first scl_rise → arb_lost pulses, sda_oe=0, no done, busy=0.
